// File: rtl/im2col_stream_if.sv
// Handshake bundle for im2col_stream: a pixel stream in and an im2col column stream out.
// The slave side is the im2col block and the master side is the surrounding pipeline.
interface im2col_stream_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [IDX_W-1:0] out_col_idx;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_col_idx
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_col_idx
    );
endinterface

// File: rtl/im2col_stream.sv
// Buffers one raster-scanned image frame, then streams its im2col matrix one kernel
// window per beat, with stride, zero padding and multi-channel pixels.
module im2col_stream #(
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4,
    parameter int CHANNELS     = 1,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    im2col_stream_if.slave  bus
);
    localparam int HP    = (IMAGE_WIDTH  - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1;
    localparam int VP    = (IMAGE_HEIGHT - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1;
    localparam int NCOL  = HP * VP;
    localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CW    = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int HW    = (HP > 1) ? $clog2(HP) : 1;
    localparam int VW    = (VP > 1) ? $clog2(VP) : 1;
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PIX_W = CHANNELS * DATA_WIDTH;

    typedef enum logic {LOAD, EMIT} state_t;

    state_t          state_reg;
    logic [PW-1:0]   pix_cnt_reg;
    logic [HW-1:0]   hpos_reg;
    logic [VW-1:0]   vpos_reg;
    logic [CW-1:0]   col_idx_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic            out_last_reg;

    logic [PIX_W-1:0] frame_buf [NPIX];

    logic in_fire;
    logic out_fire;
    logic last_pix;

    assign in_fire  = in_ready_reg && bus.in_valid;
    assign out_fire = out_valid_reg && bus.out_ready;
    assign last_pix = (pix_cnt_reg == PW'(NPIX - 1));

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            frame_buf[pix_cnt_reg] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LOAD;
            pix_cnt_reg   <= '0;
            hpos_reg      <= '0;
            vpos_reg      <= '0;
            col_idx_reg   <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_fire) begin
                        if (last_pix) begin
                            pix_cnt_reg   <= '0;
                            state_reg     <= EMIT;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (NCOL == 1);
                        end else begin
                            pix_cnt_reg <= pix_cnt_reg + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_last_reg) begin
                            state_reg     <= LOAD;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            hpos_reg      <= '0;
                            vpos_reg      <= '0;
                            col_idx_reg   <= '0;
                        end else begin
                            col_idx_reg  <= col_idx_reg + 1'b1;
                            out_last_reg <= (col_idx_reg == CW'(NCOL - 2));
                            // Window walks along a row first, then steps down.
                            if (hpos_reg == HW'(HP - 1)) begin
                                hpos_reg <= '0;
                                vpos_reg <= vpos_reg + 1'b1;
                            end else begin
                                hpos_reg <= hpos_reg + 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_last    = out_last_reg;
    assign bus.out_col_idx = col_idx_reg;

    // One pixel fetch per kernel tap; taps falling in the padding border read as zero,
    // and the whole column is forced to zero while no column is valid.
    for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_krow
        for (genvar gj = 0; gj < KERNEL_SIZE; gj++) begin : g_kcol
            int               row_i;
            int               col_i;
            logic             in_img;
            logic [PW-1:0]    addr;
            logic [PIX_W-1:0] pix;

            always_comb begin
                row_i  = int'(vpos_reg) * STRIDE + gi - PADDING;
                col_i  = int'(hpos_reg) * STRIDE + gj - PADDING;
                in_img = out_valid_reg
                         && (row_i >= 0) && (row_i < IMAGE_HEIGHT)
                         && (col_i >= 0) && (col_i < IMAGE_WIDTH);
                addr   = PW'(row_i * IMAGE_WIDTH + col_i);
                pix    = '0;
                if (in_img) begin
                    pix = frame_buf[addr];
                end
            end

            for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
                assign bus.out_data[((gc * KERNEL_SIZE + gi) * KERNEL_SIZE + gj) * DATA_WIDTH +: DATA_WIDTH]
                    = pix[gc * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_im2col_stream.sv
// Bench for im2col_stream: four configurations share one pixel stream; a scoreboard
// of expected columns is filled when a frame is driven and drained by per-DUT monitors.
module tb_im2col_stream;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    im2col_stream_if #(.IN_W(8),  .OUT_W(32), .IDX_W(4)) if0 ();
    im2col_stream_if #(.IN_W(8),  .OUT_W(72), .IDX_W(4)) if1 ();
    im2col_stream_if #(.IN_W(8),  .OUT_W(32), .IDX_W(2)) if2 ();
    im2col_stream_if #(.IN_W(16), .OUT_W(64), .IDX_W(4)) if3 ();

    im2col_stream u_def (.clk(clk), .rst_n(rst_n), .bus(if0));
    im2col_stream #(.KERNEL_SIZE(3), .PADDING(1)) u_pad (.clk(clk), .rst_n(rst_n), .bus(if1));
    im2col_stream #(.STRIDE(2)) u_str (.clk(clk), .rst_n(rst_n), .bus(if2));
    im2col_stream #(.CHANNELS(2)) u_ch2 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct {
        logic [127:0] data;
        int           idx;
        logic         last;
    } col_t;

    col_t q0[$];
    col_t q1[$];
    col_t q2[$];
    col_t q3[$];

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel (r,c) of a frame carries base + r*4 + c + 1 on channel 0, plus 100 per channel.
    function automatic logic [127:0] exp_col(input int k, input int s, input int p,
                                             input int c, input int hp, input int col,
                                             input int base);
        logic [127:0] res;
        int hpos;
        int vpos;
        res  = '0;
        hpos = col % hp;
        vpos = col / hp;
        for (int ch = 0; ch < c; ch++)
            for (int ki = 0; ki < k; ki++)
                for (int kj = 0; kj < k; kj++) begin
                    int row;
                    int cl;
                    int v;
                    row = vpos * s + ki - p;
                    cl  = hpos * s + kj - p;
                    v   = 0;
                    if (row >= 0 && row < 4 && cl >= 0 && cl < 4)
                        v = base + row * 4 + cl + 1 + ch * 100;
                    res[((ch * k + ki) * k + kj) * 8 +: 8] = 8'(v);
                end
        return res;
    endfunction

    function automatic void push_frame(input int dut, input int base);
        int k, s, p, c, hp, n;
        col_t e;
        case (dut)
            1:       begin k = 3; s = 1; p = 1; c = 1; hp = 4; n = 16; end
            2:       begin k = 2; s = 2; p = 0; c = 1; hp = 2; n = 4;  end
            3:       begin k = 2; s = 1; p = 0; c = 2; hp = 3; n = 9;  end
            default: begin k = 2; s = 1; p = 0; c = 1; hp = 3; n = 9;  end
        endcase
        for (int col = 0; col < n; col++) begin
            e.data = exp_col(k, s, p, c, hp, col, base);
            e.idx  = col;
            e.last = (col == n - 1);
            case (dut)
                1:       q1.push_back(e);
                2:       q2.push_back(e);
                3:       q3.push_back(e);
                default: q0.push_back(e);
            endcase
        end
    endfunction

    task automatic mon_col(input int dut, input logic [127:0] data, input int idx, input logic last);
        col_t e;
        int   n;
        case (dut)
            1:       n = q1.size();
            2:       n = q2.size();
            3:       n = q3.size();
            default: n = q0.size();
        endcase
        check($sformatf("u%0d_expected_col_pending", dut), 128'(n != 0), 128'(1));
        if (n != 0) begin
            case (dut)
                1:       e = q1.pop_front();
                2:       e = q2.pop_front();
                3:       e = q3.pop_front();
                default: e = q0.pop_front();
            endcase
            $display("u%0d col idx=%0d last=%0b data=%0h", dut, idx, last, data);
            check($sformatf("u%0d_col%0d_data", dut, e.idx), data, e.data);
            check($sformatf("u%0d_col%0d_idx_last", dut, e.idx),
                  128'({32'(idx), last}), 128'({32'(e.idx), e.last}));
        end
    endtask

    always @(negedge clk) if (if0.out_valid && if0.out_ready)
        mon_col(0, 128'(if0.out_data), int'(if0.out_col_idx), if0.out_last);
    always @(negedge clk) if (if1.out_valid && if1.out_ready)
        mon_col(1, 128'(if1.out_data), int'(if1.out_col_idx), if1.out_last);
    always @(negedge clk) if (if2.out_valid && if2.out_ready)
        mon_col(2, 128'(if2.out_data), int'(if2.out_col_idx), if2.out_last);
    always @(negedge clk) if (if3.out_valid && if3.out_ready)
        mon_col(3, 128'(if3.out_data), int'(if3.out_col_idx), if3.out_last);

    task automatic drive_pix(input bit v, input int pix, input bit all_duts);
        if0.in_valid = v;
        if0.in_data  = 8'(pix);
        if (all_duts) begin
            if1.in_valid = v;
            if1.in_data  = 8'(pix);
            if2.in_valid = v;
            if2.in_data  = 8'(pix);
            if3.in_valid = v;
            if3.in_data  = {8'(pix + 100), 8'(pix)};
        end
    endtask

    // Streams 16 pixels base+1..base+16; returns at the negedge after the last handshake.
    task automatic send_frame(input int base, input bit bubbles, input bit all_duts);
        bit hs;
        int guard;
        push_frame(0, base);
        if (all_duts) begin
            push_frame(1, base);
            push_frame(2, base);
            push_frame(3, base);
        end
        for (int i = 0; i < 16; i++) begin
            if (bubbles && (i % 2 == 1)) begin
                drive_pix(1'b0, 0, all_duts);
                @(posedge clk); #1;
            end
            drive_pix(1'b1, base + i + 1, all_duts);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 200) begin
                @(negedge clk);
                hs = if0.in_ready;
                if (i == 15 && hs) check("out_valid_before_last_pixel", 128'(if0.out_valid), 128'(0));
                @(posedge clk); #1;
                guard++;
            end
            check($sformatf("in_handshake_pix%0d", base + i + 1), 128'(hs), 128'(1));
        end
        drive_pix(1'b0, 0, all_duts);
        @(negedge clk);
        check("first_col_latency_out_valid", 128'(if0.out_valid), 128'(1));
        check("first_col_latency_in_ready", 128'(if0.in_ready), 128'(0));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard_drained", 128'(q0.size() + q1.size() + q2.size() + q3.size()), 128'(0));
    endtask

    task automatic wait_col(input int idx);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        while (int'(if0.out_col_idx) != idx && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("reached_col%0d", idx), 128'(if0.out_col_idx), 128'(idx));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  128'(if0.in_ready),    128'(1));
        check({tag, "_out_valid"}, 128'(if0.out_valid),   128'(0));
        check({tag, "_out_last"},  128'(if0.out_last),    128'(0));
        check({tag, "_out_data"},  128'(if0.out_data),    128'(0));
        check({tag, "_col_idx"},   128'(if0.out_col_idx), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        drive_pix(1'b0, 0, 1'b1);
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        if2.out_ready = 1'b1;
        if3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
        @(posedge clk); #1;

        // Frame A: every configuration sees 1..16 with no gaps.
        send_frame(0, 1'b0, 1'b1);
        wait_drain();

        // Frame B: input bubbles, then a three-cycle stall on column 4.
        send_frame(0, 1'b1, 1'b0);
        wait_col(4);
        if0.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_data", i), 128'(if0.out_data), 128'(32'h0B0A0706));
            check($sformatf("stall%0d_idx", i), 128'(if0.out_col_idx), 128'(4));
            check($sformatf("stall%0d_valid", i), 128'(if0.out_valid), 128'(1));
            @(posedge clk); #1;
        end
        if0.out_ready = 1'b1;

        // Frame C (17..32) is offered while B is still emitting.
        send_frame(16, 1'b0, 1'b0);
        wait_drain();

        // Frame D is cut short by reset while column 3 is on the bus.
        send_frame(0, 1'b0, 1'b0);
        wait_col(3);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("mid_emit_reset");
        q0.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame E after the reset.
        send_frame(0, 1'b0, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/im2col_stream.md
Name: im2col_stream

Overview:
Sequential, parametrised successor to the combinational 2-D im2col. Accepts one image frame as a raster-scanned pixel stream (all channels per beat) over a valid/ready handshake and buffers it internally. It then emits the im2col matrix one column (one kernel window) per beat over a second valid/ready handshake. Stride, zero padding and multi-channel input are supported. It sits between the image source and the convolution MAC array.

Parameters:
IMAGE_WIDTH, 4, image columns (W)
IMAGE_HEIGHT, 4, image rows (H)
CHANNELS, 1, channels per pixel (C)
KERNEL_SIZE, 2, square kernel side (K); must be <= min(W,H)+2*PADDING
STRIDE, 1, window step in both axes, >=1
PADDING, 0, zero border width on all four sides, >=0
DATA_WIDTH, 8, bits per element (DW)
Derived: HP=(W-K+2P)/STRIDE+1, VP=(H-K+2P)/STRIDE+1, NCOL=HP*VP, CW=$clog2(NCOL) (min 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel beat valid
in_ready  out  1  block accepts a pixel
in_data  in  C*DW  pixel; channel c at [c*DW +: DW]
out_valid  out  1  column beat valid
out_ready  in  1  consumer accepts a column
out_data  out  K*K*C*DW  im2col column; element e=(c*K+ki)*K+kj at [e*DW +: DW]
out_last  out  1  final column of frame (qualified by out_valid)
out_col_idx  out  CW  current column index = vpos*HP+hpos

Behaviour:
- Reset (async assert, sync release): state=LOAD, pixel/position counters=0, buffer contents don't-care. Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, out_col_idx=0.
- Frame buffer: H*W entries of C*DW bits, registers; written in raster order (row 0 col 0 first).
- LOAD: in_ready=1, out_valid=0. Each in_valid&&in_ready cycle writes buffer[pix_cnt] and increments pix_cnt. On the handshake with pix_cnt==H*W-1, go to EMIT and clear pix_cnt.
- EMIT: in_ready=0, out_valid=1 from the cycle after the last input handshake. Latency, last pixel accepted -> first column valid: 1 cycle.
- Column (hpos,vpos) element (c,ki,kj) = image[vpos*STRIDE+ki-P][hpos*STRIDE+kj-P] channel c, or 0 when the row or column index falls outside [0,H-1]/[0,W-1].
- Column order: hpos fastest, then vpos. out_col_idx tracks it.
- out_data and out_col_idx are held stable while out_valid && !out_ready. Advance happens only on the handshake.
- out_last=1 exactly when out_col_idx==NCOL-1. On the handshake with out_last=1, go to LOAD: positions reset to 0 and in_ready=1 the next cycle. Back-to-back frames need no idle cycle beyond this.
- in_valid is ignored in EMIT (no write, no counter change). out_ready is ignored in LOAD.
- out_data is driven to 0 whenever out_valid=0.
- rst_n asserted mid-LOAD or mid-EMIT: immediate return to reset values. The partial frame is discarded and the next frame starts at pixel 0.
- out_data is combinational from the buffer and the registered positions. No combinational path from in_valid or out_ready to any output except through state.

Test Plan:
- Defaults, 4x4 pixels 1..16 streamed without gaps -> 9 columns. col0={1,2,5,6}, col4={6,7,10,11}, col8={11,12,15,16}. out_last only on col8. First out_valid 1 cycle after pixel 16 is accepted.
- PADDING=1, K=3, 4x4 1..16 -> 16 columns. col0={0,0,0,0,1,2,0,5,6}, col15={11,12,0,15,16,0,0,0,0}.
- STRIDE=2, K=2, 4x4 1..16 -> 4 columns: {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16}.
- CHANNELS=2, pixel p = {ch1=p+100, ch0=p}, defaults otherwise -> col0 = ch0 {1,2,5,6} followed by ch1 {101,102,105,106}.
- Backpressure and bubbles: in_valid toggling 1/0 during LOAD; out_ready low for 3 cycles at col4 -> out_data stays {6,7,10,11} and out_col_idx stays 4. No columns are lost or duplicated. A second frame 17..32 follows immediately with col0={17,18,21,22}.
- Reset: assert rst_n low during col3 of EMIT -> out_valid=0 and in_ready=1 immediately. A fresh frame afterwards yields correct col0={1,2,5,6}.
